beta_hazard_ctl: RTL



---
 rtl/beta_hazard_ctl.sv | 119 +++++++++++
 1 files changed

// File: rtl/beta_hazard_ctl.sv
// rtl/beta_hazard_ctl.sv - Beta pipeline hazard, bypass, interrupt and halt controller
module beta_hazard_ctl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rf_ra1,
    input  logic [4:0]  rf_ra2,
    input  logic [1:0]  rf_pcsel,
    input  logic        rf_illop,
    input  logic        rf_halt,
    input  logic [6:0]  alu_baddr,
    input  logic [6:0]  mem_baddr,
    input  logic [6:0]  wb_baddr,
    input  logic        irq,
    output logic        if_stall,
    output logic        rf_stall,
    output logic [1:0]  rf_irsrc,
    output logic [1:0]  alu_irsrc,
    output logic [1:0]  pc_override,
    output logic [1:0]  byp1_sel,
    output logic [1:0]  byp2_sel,
    output logic        irq_ack,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MASK = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t state, state_next;
    logic   hazard;
    logic   take_irq;

    // Youngest producer wins; register 31 is hardwired zero and never bypassed.
    function automatic logic [1:0] byp_pick(input logic [4:0] ra, input logic [6:0] a,
                                            input logic [6:0] m, input logic [6:0] w);
        if (ra == 5'd31)         return 2'd0;
        else if (a[4:0] == ra)   return 2'd1;
        else if (m[4:0] == ra)   return 2'd2;
        else if (w[4:0] == ra)   return 2'd3;
        else                     return 2'd0;
    endfunction

    function automatic logic is_late(input logic [1:0] sel, input logic [6:0] a,
                                     input logic [6:0] m);
        return ((sel == 2'd1) && a[6]) || ((sel == 2'd2) && m[6]);
    endfunction

    assign byp1_sel = byp_pick(rf_ra1, alu_baddr, mem_baddr, wb_baddr);
    assign byp2_sel = byp_pick(rf_ra2, alu_baddr, mem_baddr, wb_baddr);
    assign hazard   = is_late(byp1_sel, alu_baddr, mem_baddr) ||
                      is_late(byp2_sel, alu_baddr, mem_baddr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        if_stall    = 1'b0;
        rf_stall    = 1'b0;
        rf_irsrc    = 2'd0;
        alu_irsrc   = 2'd0;
        pc_override = 2'd0;
        take_irq    = 1'b0;
        case (state)
            ST_HALT: begin
                if_stall  = 1'b1;
                rf_stall  = 1'b1;
                alu_irsrc = 2'd2;
            end
            default: begin
                if (state == ST_MASK && !irq) begin
                    state_next = ST_RUN;
                end
                // Hazard freezes everything else; pending events retry next cycle.
                if (hazard) begin
                    if_stall  = 1'b1;
                    rf_stall  = 1'b1;
                    alu_irsrc = 2'd2;
                end else if (rf_halt) begin
                    if_stall   = 1'b1;
                    rf_stall   = 1'b1;
                    alu_irsrc  = 2'd2;
                    state_next = ST_HALT;
                end else if (state == ST_RUN && irq) begin
                    take_irq    = 1'b1;
                    rf_irsrc    = 2'd1;
                    pc_override = 2'd2;
                    state_next  = ST_MASK;
                end else if (rf_illop) begin
                    rf_irsrc    = 2'd1;
                    pc_override = 2'd1;
                    alu_irsrc   = 2'd2;
                end else if (rf_pcsel != 2'd0) begin
                    rf_irsrc = 2'd2;
                end
            end
        endcase
    end

    assign irq_ack = take_irq && !reset;
    assign halted  = (state == ST_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (hazard && state != ST_HALT && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule
